legv8_exec_arith_unit: RTL and testbench
========================================

Name: legv8_exec_arith_unit

Overview:
Execute-stage arithmetic block for the LEGv8 single-cycle core. It merges three functions: the 64-bit ALU, the PC+4 incrementer, and the branch-target adder. It produces ALU result and zero flag for register writeback, data-memory addressing and branch resolution, plus next-sequential and branch-target PCs for the PC mux. All outputs are registered behind one clock stage.

Parameters:
DATA_W, 64, ALU operand/result width
ADDR_W, 32, PC / instruction-address width
PC_INC, 4, constant added to pc for the sequential next address
OFFSET_SHIFT, 2, left shift applied to branch_offset before the add (word offset to byte offset)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands valid this cycle; outputs capture only when high
a_in  input  DATA_W  ALU operand A (register read port 1)
b_in  input  DATA_W  ALU operand B (register port 2 or sign-extended immediate)
alu_operation  input  3  ALU function select
pc  input  ADDR_W  current program counter
branch_offset  input  ADDR_W  signed branch displacement in words
out_valid  output  1  registered copy of in_valid
result  output  DATA_W  registered ALU result
zero  output  1  registered flag, 1 when the captured ALU result is all zeros
pc_plus4  output  ADDR_W  registered pc + PC_INC
branch_target  output  ADDR_W  registered pc + (branch_offset << OFFSET_SHIFT)

Behaviour:
- Latency is exactly 1 cycle. Inputs are sampled at the rising edge where in_valid=1, and the outputs are valid from that edge onward.
- in_valid=0 at an edge: result, zero, pc_plus4 and branch_target hold their previous values; out_valid goes to 0.
- reset=1 at an edge: out_valid=0, result=0, zero=1 (consistent with result=0), pc_plus4=0, branch_target=0. Reset overrides in_valid in the same cycle.
- Reset mid-stream discards the pending capture. The first valid input after reset deasserts produces out_valid one cycle later.
- ALU encodings:
  - 000 AND
  - 001 OR
  - 010 ADD (a+b)
  - 011 XOR
  - 100 NOR
  - 101 result 0
  - 110 SUB (a-b)
  - 111 PASS_B (result=b_in)
- ADD and SUB are modulo 2^DATA_W; carries and borrows are discarded.
- zero is computed from the same-cycle ALU result and registered with it.
- pc_plus4 = (pc + PC_INC) mod 2^ADDR_W; 0xFFFFFFFC wraps to 0x00000000.
- branch_target = (pc + (branch_offset << OFFSET_SHIFT)) mod 2^ADDR_W. branch_offset is two's complement, and the shift drops the top bits. Negative offsets give backward targets.
- No X propagation: every output is defined from reset onward.

Optional Feature:
Macro ALU_FLAGS_EN.
- Defined: adds registered outputs carry (1 bit) and overflow (1 bit).
  - carry is the unsigned carry-out of ADD, or NOT borrow for SUB.
  - overflow is signed two's-complement overflow of ADD/SUB.
  - Both are 0 for all other operations and 0 on reset. They hold and update under the same rules as result.
- Undefined: these ports do not exist and no flag logic is synthesized.

Test Plan:
- reset=1 for 2 cycles with random inputs and in_valid=1 -> out_valid=0, result=0, zero=1, pc_plus4=0, branch_target=0.
- in_valid=1, alu_operation=010, a=5, b=7 -> next cycle result=12, zero=0, out_valid=1. Same with op=110, a=7, b=7 -> result=0, zero=1.
- Logic sweep with a=0xF0F0_0000_0000_00FF, b=0x0FF0_0000_0000_0F0F:
  - AND -> 0x00F0_0000_0000_000F
  - OR -> 0xFFF0_0000_0000_0FFF
  - XOR -> 0xFF00_0000_0000_0FF0
  - NOR -> 0x000F_FFFF_FFFF_F000
  - PASS_B -> b
  - op 101 -> 0 with zero=1
- pc=0x0000_0010, branch_offset=0xFFFF_FFFE (-2) -> pc_plus4=0x14, branch_target=0x08. pc=0xFFFF_FFFC -> pc_plus4=0.
- Apply a valid op, then in_valid=0 for 3 cycles with changing inputs -> outputs hold, out_valid=0. Assert reset during a valid cycle -> that cycle's result is not captured and outputs clear.
- With ALU_FLAGS_EN: ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, overflow=1, carry=0. ADD a=all-ones, b=1 -> result=0, zero=1, carry=1, overflow=0.

Source files
------------

// File: rtl/legv8_exec_arith_unit_if.sv
// legv8_exec_arith_unit_if: operand/result bus; master drives in_valid, a_in, b_in, alu_operation, pc, branch_offset; slave returns out_valid, result, zero, pc_plus4, branch_target (+ carry, overflow when ALU_FLAGS_EN)
interface legv8_exec_arith_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic in_valid;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [2:0] alu_operation;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] branch_offset;
  logic out_valid;
  logic [DATA_W-1:0] result;
  logic zero;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_target;
`ifdef ALU_FLAGS_EN
  logic carry;
  logic overflow;
  modport master (
    output in_valid, a_in, b_in, alu_operation, pc, branch_offset,
    input out_valid, result, zero, pc_plus4, branch_target, carry, overflow
  );
  modport slave (
    input in_valid, a_in, b_in, alu_operation, pc, branch_offset,
    output out_valid, result, zero, pc_plus4, branch_target, carry, overflow
  );
`else
  modport master (
    output in_valid, a_in, b_in, alu_operation, pc, branch_offset,
    input out_valid, result, zero, pc_plus4, branch_target
  );
  modport slave (
    input in_valid, a_in, b_in, alu_operation, pc, branch_offset,
    output out_valid, result, zero, pc_plus4, branch_target
  );
`endif
endinterface

// File: rtl/legv8_exec_arith_unit.sv
// legv8_exec_arith_unit: registered LEGv8 ALU + PC+4 + branch-target adder; ports clk, reset (sync active-high), bus (legv8_exec_arith_unit_if.slave); macro ALU_FLAGS_EN adds registered carry/overflow
module legv8_exec_arith_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int PC_INC = 4,
  parameter int OFFSET_SHIFT = 2
) (
  input logic clk,
  input logic reset,
  legv8_exec_arith_unit_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_ZERO = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  logic [DATA_W-1:0] a, b, sum, diff, alu;
  logic [DATA_W-1:0] result_d, result_q;
  logic [ADDR_W-1:0] pc_plus4_d, pc_plus4_q, branch_target_d, branch_target_q;
  logic valid_d, valid_q, zero_d, zero_q;
  assign a = bus.a_in;
  assign b = bus.b_in;
`ifdef ALU_FLAGS_EN
  logic add_c, sub_c, carry_d, carry_q, overflow_d, overflow_q;
  assign {add_c, sum} = {1'b0, a} + {1'b0, b};
  assign {sub_c, diff} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
`else
  assign sum = a + b;
  assign diff = a - b;
`endif
  always_comb begin
    case (bus.alu_operation)
      OP_AND: alu = a & b;
      OP_OR: alu = a | b;
      OP_ADD: alu = sum;
      OP_XOR: alu = a ^ b;
      OP_NOR: alu = ~(a | b);
      OP_ZERO: alu = '0;
      OP_SUB: alu = diff;
      default: alu = b;
    endcase
  end
  always_comb begin
    valid_d = bus.in_valid;
    result_d = bus.in_valid ? alu : result_q;
    zero_d = bus.in_valid ? (alu == '0) : zero_q;
    pc_plus4_d = bus.in_valid ? bus.pc + ADDR_W'(PC_INC) : pc_plus4_q;
    branch_target_d = bus.in_valid ? bus.pc + (bus.branch_offset << OFFSET_SHIFT) : branch_target_q;
`ifdef ALU_FLAGS_EN
    carry_d = !bus.in_valid ? carry_q :
              bus.alu_operation == OP_ADD ? add_c :
              bus.alu_operation == OP_SUB ? sub_c : 1'b0;
    overflow_d = !bus.in_valid ? overflow_q :
                 bus.alu_operation == OP_ADD ? (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]) :
                 bus.alu_operation == OP_SUB ? (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]) : 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b1;
      pc_plus4_q <= '0;
      branch_target_q <= '0;
`ifdef ALU_FLAGS_EN
      carry_q <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      result_q <= result_d;
      zero_q <= zero_d;
      pc_plus4_q <= pc_plus4_d;
      branch_target_q <= branch_target_d;
`ifdef ALU_FLAGS_EN
      carry_q <= carry_d;
      overflow_q <= overflow_d;
`endif
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.result = result_q;
  assign bus.zero = zero_q;
  assign bus.pc_plus4 = pc_plus4_q;
  assign bus.branch_target = branch_target_q;
`ifdef ALU_FLAGS_EN
  assign bus.carry = carry_q;
  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_legv8_exec_arith_unit.sv
// tb_legv8_exec_arith_unit: randomized and directed checks of legv8_exec_arith_unit against a behavioural model
module tb_legv8_exec_arith_unit;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int VW = 2 + DW + 2 * AW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic m_valid, m_zero, m_c, m_o;
  logic [DW-1:0] m_result;
  logic [AW-1:0] m_pc4, m_bt;
  legv8_exec_arith_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  legv8_exec_arith_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  wire [VW-1:0] obs = {bus.out_valid, bus.zero, bus.result, bus.pc_plus4, bus.branch_target};
  wire [VW-1:0] cleared = {1'b0, 1'b1, {DW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}};
`ifdef ALU_FLAGS_EN
  wire [1:0] obs_f = {bus.carry, bus.overflow};
`endif
  function automatic logic [VW-1:0] mvec();
    return {m_valid, m_zero, m_result, m_pc4, m_bt};
  endfunction
  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return '0;
      3'd6: return a - b;
      default: return b;
    endcase
  endfunction
  function automatic logic [1:0] ref_flags(input logic [2:0] op, input logic [DW-1:0] a, b);
    logic [DW:0] u;
    logic signed [DW:0] s;
    if (op == 3'd2) begin
      u = {1'b0, a} + {1'b0, b};
      s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
      return {u[DW], s[DW] ^ s[DW-1]};
    end
    if (op == 3'd6) begin
      s = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
      return {a >= b, s[DW] ^ s[DW-1]};
    end
    return 2'b00;
  endfunction
  task automatic apply(input logic v, input logic [DW-1:0] a, b, input logic [2:0] op,
                       input logic [AW-1:0] p, off);
    bus.in_valid = v;
    bus.a_in = a;
    bus.b_in = b;
    bus.alu_operation = op;
    bus.pc = p;
    bus.branch_offset = off;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_result = '0; m_zero = 1'b1; m_pc4 = '0; m_bt = '0; m_c = 1'b0; m_o = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_result = ref_alu(op, a, b);
        m_zero = (m_result == 0);
        m_pc4 = p + 32'd4;
        m_bt = p + off * 32'd4;
        {m_c, m_o} = ref_flags(op, a, b);
      end
    end
    #1;
  endtask
  function automatic logic [DW-1:0] r64();
    return {$urandom, $urandom};
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, r64(), r64(), 3'($urandom_range(0, 7)), $urandom, $urandom);
      n_cmp++;
      if (obs !== cleared) begin n_bad++; $display("FAIL reset[%0d] got %h want %h", i, obs, cleared); end
`ifdef ALU_FLAGS_EN
      n_cmp++;
      if (obs_f !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", obs_f); end
`endif
    end
    reset = 1'b0;
  endtask
  task automatic test_add_sub();
    apply(1'b1, 64'd5, 64'd7, 3'b010, 32'h100, 32'd1);
    n_cmp++;
    if ({bus.out_valid, bus.zero, bus.result} !== {1'b1, 1'b0, 64'd12}) begin
      n_bad++; $display("FAIL add got v=%b z=%b r=%h want v=1 z=0 r=c", bus.out_valid, bus.zero, bus.result);
    end
    apply(1'b1, 64'd7, 64'd7, 3'b110, 32'h104, 32'd1);
    n_cmp++;
    if ({bus.out_valid, bus.zero, bus.result} !== {1'b1, 1'b1, 64'd0}) begin
      n_bad++; $display("FAIL sub got v=%b z=%b r=%h want v=1 z=1 r=0", bus.out_valid, bus.zero, bus.result);
    end
  endtask
  task automatic test_logic();
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd7, 3'd5};
    logic [DW-1:0] exps [6] = '{64'h00F0_0000_0000_000F, 64'hFFF0_0000_0000_0FFF, 64'hFF00_0000_0000_0FF0,
                               64'h000F_FFFF_FFFF_F000, 64'h0FF0_0000_0000_0F0F, 64'h0};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, ops[i], $urandom, $urandom);
      n_cmp++;
      if ({bus.zero, bus.result} !== {exps[i] == 0, exps[i]}) begin
        n_bad++; $display("FAIL logic op=%0d got z=%b r=%h want z=%b r=%h", ops[i], bus.zero, bus.result, exps[i] == 0, exps[i]);
      end
    end
  endtask
  task automatic test_pc();
    apply(1'b1, r64(), r64(), 3'd2, 32'h0000_0010, 32'hFFFF_FFFE);
    n_cmp++;
    if ({bus.pc_plus4, bus.branch_target} !== {32'h14, 32'h8}) begin
      n_bad++; $display("FAIL pc_back got pc4=%h bt=%h want 14 8", bus.pc_plus4, bus.branch_target);
    end
    apply(1'b1, r64(), r64(), 3'd2, 32'hFFFF_FFFC, 32'h0000_0003);
    n_cmp++;
    if ({bus.pc_plus4, bus.branch_target} !== {32'h0, 32'h8}) begin
      n_bad++; $display("FAIL pc_wrap got pc4=%h bt=%h want 0 8", bus.pc_plus4, bus.branch_target);
    end
    apply(1'b1, r64(), r64(), 3'd2, 32'h0000_1000, 32'h4000_0001);
    n_cmp++;
    if (bus.branch_target !== 32'h0000_1004) begin
      n_bad++; $display("FAIL bt_shift got %h want 00001004", bus.branch_target);
    end
  endtask
  task automatic test_hold();
    logic [VW-1:0] saved;
    apply(1'b1, r64(), r64(), 3'd2, $urandom, $urandom);
    saved = mvec();
    n_cmp++;
    if (obs !== saved) begin n_bad++; $display("FAIL hold_capture got %h want %h", obs, saved); end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, r64(), r64(), 3'($urandom_range(0, 7)), $urandom, $urandom);
      n_cmp++;
      if (obs !== {1'b0, saved[VW-2:0]}) begin
        n_bad++; $display("FAIL hold[%0d] got %h want %h", i, obs, {1'b0, saved[VW-2:0]});
      end
    end
  endtask
  task automatic test_reset_midstream();
    apply(1'b1, 64'd9, 64'd3, 3'd6, 32'h40, 32'h1);
    reset = 1'b1;
    apply(1'b1, 64'd5, 64'd7, 3'd2, 32'h80, 32'h2);
    n_cmp++;
    if (obs !== cleared) begin n_bad++; $display("FAIL mid_reset got %h want %h", obs, cleared); end
    reset = 1'b0;
    apply(1'b0, 64'd5, 64'd7, 3'd2, 32'h80, 32'h2);
    n_cmp++;
    if (obs !== cleared) begin n_bad++; $display("FAIL post_reset_idle got %h want %h", obs, cleared); end
    apply(1'b1, 64'd5, 64'd7, 3'd2, 32'h80, 32'h2);
    n_cmp++;
    if ({bus.out_valid, bus.result, bus.pc_plus4, bus.branch_target} !== {1'b1, 64'd12, 32'h84, 32'h88}) begin
      n_bad++; $display("FAIL first_after_reset got v=%b r=%h pc4=%h bt=%h want 1 c 84 88",
                        bus.out_valid, bus.result, bus.pc_plus4, bus.branch_target);
    end
  endtask
  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      a = r64();
      b = ($urandom_range(0, 7) == 0) ? a : r64();
      apply($urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)), $urandom, $urandom);
      n_cmp++;
      if (obs !== mvec()) begin n_bad++; $display("FAIL random[%0d] got %h want %h", i, obs, mvec()); end
`ifdef ALU_FLAGS_EN
      n_cmp++;
      if (obs_f !== {m_c, m_o}) begin n_bad++; $display("FAIL random_flags[%0d] got %b want %b", i, obs_f, {m_c, m_o}); end
`endif
    end
    reset = 1'b0;
  endtask
`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    apply(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd2, 32'h0, 32'h0);
    n_cmp++;
    if ({bus.result, obs_f} !== {64'h8000_0000_0000_0000, 2'b01}) begin
      n_bad++; $display("FAIL flags_ovf got r=%h co=%b want 8000000000000000 01", bus.result, obs_f);
    end
    apply(1'b1, {DW{1'b1}}, 64'd1, 3'd2, 32'h0, 32'h0);
    n_cmp++;
    if ({bus.zero, bus.result, obs_f} !== {1'b1, 64'd0, 2'b10}) begin
      n_bad++; $display("FAIL flags_carry got z=%b r=%h co=%b want 1 0 10", bus.zero, bus.result, obs_f);
    end
    apply(1'b1, 64'd0, 64'd1, 3'd6, 32'h0, 32'h0);
    n_cmp++;
    if (obs_f !== 2'b00) begin n_bad++; $display("FAIL flags_borrow got %b want 00", obs_f); end
    apply(1'b1, 64'h8000_0000_0000_0000, 64'd1, 3'd6, 32'h0, 32'h0);
    n_cmp++;
    if (obs_f !== 2'b11) begin n_bad++; $display("FAIL flags_sub_ovf got %b want 11", obs_f); end
    apply(1'b1, {DW{1'b1}}, 64'd1, 3'd0, 32'h0, 32'h0);
    n_cmp++;
    if (obs_f !== 2'b00) begin n_bad++; $display("FAIL flags_logic got %b want 00", obs_f); end
  endtask
`endif
  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_pc();
    test_hold();
    test_reset_midstream();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
